// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder built from two half-adder stages and an OR on their carries.
module full_adder_1b (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half adder on the operands, second folds in the carry.
  always_comb begin
    hs1 = x ^ y;
    hc1 = x & y;
    s   = hs1 ^ cin;
    hc2 = hs1 & cin;
    co  = hc1 | hc2;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift out LSB-first through one full adder
// cell, with the sum reassembled MSB-in over WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder_1b u_fa (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // FSM, operand shifters, carry, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // start is deliberately ignored here; operands are already captured.
          sum   <= {fa_s, sum[WIDTH-1:1]};
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            cout  <= fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Back-to-back load: no idle cycle between results.
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random operands
// compared against plain integer addition.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  // Reference: full-precision unsigned sum.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Launches one operation from IDLE and observes it for `window` cycles.
  // Optionally re-pulses start with other operands at cycle glitch_n.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input int glitch_n, input int window,
                       output int done_n, output int done_cnt, output int busy_cnt,
                       output int overlap, output logic [W-1:0] rs, output logic rc);
    done_n = 0; done_cnt = 0; busy_cnt = 0; overlap = 0; rs = '0; rc = 1'b0;
    start = 1'b1; a = oa; b = ob;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int n = 1; n <= window; n++) begin
      if (n == glitch_n) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_cnt++;
        if (done_n == 0) begin
          done_n = n; rs = sum; rc = cout;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, sum, cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b sum=%h cout=%b need 0 0 00 0",
                 i, busy, done, sum, cout);
      end
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input int glitch_n, input int window);
    int dn, dc, bc, ov;
    logic [W-1:0] rs;
    logic rc;
    logic [W:0] exp;
    exp = ref_add(oa, ob);
    do_op(oa, ob, glitch_n, window, dn, dc, bc, ov, rs, rc);
    n_checks++;
    if ({rc, rs} !== exp) begin
      n_fail++;
      $display("FAIL %s result: cout,sum=%b,%h need %b,%h", name, rc, rs, exp[W], exp[W-1:0]);
    end
    n_checks++;
    if (dn !== W + 1) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d need %0d", name, dn, W + 1);
    end
    n_checks++;
    if (bc !== W) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d need %0d", name, bc, W);
    end
    n_checks++;
    if (dc !== 1 || ov !== 0) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d overlap %0d need 1 overlap 0", name, dc, ov);
    end
  endtask

  task automatic test_basic();
    check_op("0F+01", 8'h0F, 8'h01, 0, W + 4);
  endtask

  task automatic test_overflow();
    check_op("FF+01", 8'hFF, 8'h01, 0, W + 4);
    check_op("FF+FF", 8'hFF, 8'hFF, 0, W + 4);
    // Result must persist through IDLE.
    repeat (5) @(negedge clk);
    n_checks++;
    if ({cout, sum} !== 9'h1FE || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_result: cout,sum=%b,%h busy=%b done=%b need 1,fe 0 0",
               cout, sum, busy, done);
    end
  endtask

  task automatic test_ignore_start();
    check_op("busy_start", 8'h12, 8'h34, 3, W + 12);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; a = 8'h80; b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b need 0 0 00 0",
               busy, done, sum, cout);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy=%b done=%b need 0 0", busy, done);
    end
    check_op("80+80", 8'h80, 8'h80, 0, W + 4);
  endtask

  task automatic test_back_to_back();
    int done_cnt, gaps, bad_pos, bad_res;
    logic [W:0] exp;
    exp = ref_add(8'h01, 8'h02);
    done_cnt = 0; gaps = 0; bad_pos = 0; bad_res = 0;
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    for (int n = 1; n <= 4 * (W + 1); n++) begin
      if (!(busy ^ done)) gaps++;
      if (done) begin
        done_cnt++;
        if (n % (W + 1) != 0) bad_pos++;
        if ({cout, sum} !== exp) bad_res++;
      end
      if (n == 4 * (W + 1)) start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (done_cnt !== 4) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d need 4", done_cnt);
    end
    n_checks++;
    if (bad_pos !== 0 || bad_res !== 0) begin
      n_fail++;
      $display("FAIL b2b_spacing_result: misplaced %0d wrong %0d need 0 0", bad_pos, bad_res);
    end
    n_checks++;
    if (gaps !== 0) begin
      n_fail++;
      $display("FAIL b2b_no_idle: idle/overlap cycles %0d need 0", gaps);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_return_idle: busy=%b done=%b need 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      check_op("random", ra, rb, 0, W + 4);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a 1-bit adder cell and a registered carry.
- Consumes two parallel operands, presents them LSB-first to the adder cell, and reassembles the sum one bit per clock.
- Sits directly upstream of result consumers and trades latency (WIDTH cycles) for a single adder cell instead of a ripple chain.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- start  input  1  request to load a/b and begin an addition.
- a  input  WIDTH  operand A, sampled only on an accepted start.
- b  input  WIDTH  operand B, sampled only on an accepted start.
- busy  output  1  high while in SHIFT state.
- done  output  1  single-cycle pulse: sum/cout valid.
- sum  output  WIDTH  result, low WIDTH bits of a+b.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, carry reg=0, bit counter=0, operand shift regs=0. Reset wins over every other event, including mid-SHIFT; the partial result is discarded.
- States:
  - IDLE: start=1 -> load a, b into shift regs; clear carry, counter and sum; go to SHIFT.
  - SHIFT: each edge computes s = a_sr[0]^b_sr[0]^carry and next carry = majority(a_sr[0], b_sr[0], carry). s is shifted into sum MSB (sum shifts right). a_sr and b_sr shift right. Counter increments. When counter reaches WIDTH-1 on this edge, go to DONE and latch cout = next carry.
  - DONE: done=1 for exactly this one cycle. start=1 -> load new operands and go to SHIFT (back-to-back, zero idle). Otherwise go to IDLE.
- Latency: start sampled at edge k; SHIFT occupies the cycles following edges k..k+WIDTH-1; done is high in the cycle following edge k+WIDTH.
- Throughput: one result per WIDTH+1 cycles.
- busy: high exactly WIDTH cycles per operation. busy and done are never high together.
- start while busy=1 is ignored; operands are not resampled and no error is flagged.
- a/b may change freely after the load edge.
- sum/cout hold their last result through IDLE until the next accepted start clears sum.
- Arithmetic: unsigned, modulo 2^WIDTH; cout is the 2^WIDTH bit. Signed interpretation is the consumer's concern.
- Counter width: $clog2(WIDTH); no wrap occurs since it is cleared on load.

Decomposition:
- Shared package/header: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- One sub-module: full_adder_1b (inputs x, y, cin; outputs s, co), purely combinational. Built from two half-adder stages plus an OR on the carries. serial_adder instantiates it once.
- FSM, counter, shift and carry registers stay in serial_adder.

Test Plan:
- rst=1 for 2 cycles, then release with start=0 -> busy=0, done=0, sum=0x00, cout=0 held for 10 cycles.
- WIDTH=8: a=0x0F, b=0x01, start 1 cycle -> busy high 8 cycles; done pulses 9 cycles after start edge; sum=0x10, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. a=0xFF, b=0xFF -> sum=0xFE, cout=1. Results hold until the next start.
- During SHIFT of 0x12+0x34, pulse start with a=0xAA, b=0x55 -> ignored; result sum=0x46, cout=0; done pulses once.
- rst asserted 4 cycles into 0x80+0x80 -> next cycle busy=0, sum=0, cout=0. New start 0x80+0x80 -> sum=0x00, cout=1.
- start held high continuously with a=0x01, b=0x02 -> done every 9 cycles, sum=0x03, no idle cycle between operations.
